// File: rtl/axb_pkg.sv
// Shared definitions for the AXB crossbar arbiters: controller states,
// default crossbar dimensions and a one-hot to binary helper.
package axb_pkg;

    localparam int AXB_MSTN = 4;
    localparam int AXB_SLVN = 8;

    typedef logic [1:0] axb_state_t;

    localparam axb_state_t ST_IDLE = 2'd0;
    localparam axb_state_t ST_ADDR = 2'd1;
    localparam axb_state_t ST_DATA = 2'd2;

    // Caller guarantees at most one bit set; the OR of indices is then exact.
    function automatic int unsigned onehot2bin(input logic [31:0] i_oh);
        int unsigned v;
        v = 0;
        for (int i = 0; i < 32; i++) begin
            if (i_oh[i]) begin
                v = v | 32'(i);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/axb_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// the pointer, wrapping from the top index back to zero.
module axb_rr_pick
    import axb_pkg::*;
#(
    parameter int MSTN = AXB_MSTN,
    parameter int IDW  = $clog2(MSTN)
) (
    input  logic [MSTN-1:0] i_eligible,
    input  logic [IDW-1:0]  i_rr_ptr,
    output logic [MSTN-1:0] o_win_oh,
    output logic [IDW-1:0]  o_win_id
);

    logic           w_found;
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;

    always_comb begin
        o_win_oh = '0;
        w_found  = 1'b0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < MSTN; k++) begin
            w_sum = {1'b0, i_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(MSTN)) begin
                w_sum = w_sum - (IDW+1)'(MSTN);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && i_eligible[w_idx]) begin
                o_win_oh[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

    assign o_win_id = IDW'(onehot2bin(32'(o_win_oh)));

endmodule

// File: rtl/axb_slv_arb.sv
// Per-slave address arbiter: round-robin grant held from the address
// handshake through the last data beat, with a data-phase watchdog.
module axb_slv_arb
    import axb_pkg::*;
#(
    parameter int              MSTN     = AXB_MSTN,
    parameter logic [MSTN-1:0] MST_MASK = {MSTN{1'b1}},
    parameter int              TMO_W    = 8,
    parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(200),
    parameter int              IDW      = $clog2(MSTN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [MSTN-1:0] m_req,
    output logic [MSTN-1:0] m_ack,
    output logic            s_valid,
    input  logic            s_ready,
    input  logic            d_done,
    output logic [MSTN-1:0] grant_oh,
    output logic [IDW-1:0]  grant_id,
    output logic            busy,
    output logic            tmo_err
);

    axb_state_t       r_state;
    logic [MSTN-1:0]  r_grant_oh;
    logic [IDW-1:0]   r_grant_id;
    logic [IDW-1:0]   r_rr_ptr;
    logic [TMO_W-1:0] r_tmo_cnt;

    logic [MSTN-1:0]  w_eligible;
    logic [MSTN-1:0]  w_win_oh;
    logic [IDW-1:0]   w_win_id;
    logic             w_addr_hs;
    logic             w_tmo_at_max;
    logic [IDW-1:0]   w_next_ptr;

    assign w_eligible = m_req & MST_MASK;

    axb_rr_pick #(
        .MSTN (MSTN),
        .IDW  (IDW)
    ) u_pick (
        .i_eligible (w_eligible),
        .i_rr_ptr   (r_rr_ptr),
        .o_win_oh   (w_win_oh),
        .o_win_id   (w_win_id)
    );

    assign w_addr_hs    = (r_state == ST_ADDR) && m_req[r_grant_id] && s_ready;
    assign w_tmo_at_max = (r_tmo_cnt == TMO_MAX);
    assign w_next_ptr   = (r_grant_id == IDW'(MSTN-1)) ? '0 : r_grant_id + IDW'(1);

    // A dropped request mid-address-phase keeps the grant; only valid follows it.
    assign s_valid  = (r_state == ST_ADDR) && m_req[r_grant_id];
    assign m_ack    = ((r_state == ST_ADDR) && s_ready) ? r_grant_oh : '0;
    assign grant_oh = r_grant_oh;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);
    assign tmo_err  = (r_state == ST_DATA) && w_tmo_at_max && !d_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_oh <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_tmo_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_eligible) begin
                        r_grant_oh <= w_win_oh;
                        r_grant_id <= w_win_id;
                        r_state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_addr_hs) begin
                        r_tmo_cnt <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Completion and watchdog expiry release the grant the same way.
                    if (d_done || w_tmo_at_max) begin
                        r_state    <= ST_IDLE;
                        r_rr_ptr   <= w_next_ptr;
                        r_grant_oh <= '0;
                        r_grant_id <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axb_slv_arb.sv
// Self-checking bench for axb_slv_arb: cycle table, hand-written corner
// sequences and randomized traffic against a transaction-rule model.
module tb_axb_slv_arb;

    localparam int N   = 4;
    localparam int TMO = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mReq = '0;
    logic [3:0] mReqB = '0;
    logic       sReady = 1'b0;
    logic       dDone = 1'b0;

    logic [3:0] mAck, grantOh;
    logic [1:0] grantId;
    logic       sValid, busy, tmoErr;

    logic [3:0] mAckB, grantOhB;
    logic [1:0] grantIdB;
    logic       sValidB, busyB, tmoErrB;

    int testsRun = 0;
    int testsFailed = 0;

    // Reference model: phase 0 idle, 1 address, 2 data.
    int mdlPhase, mdlOwner, mdlPtr, mdlCnt;

    always #5 clk = ~clk;

    axb_slv_arb #(
        .MSTN(4), .MST_MASK(4'b1111), .TMO_W(8), .TMO_MAX(8'd10)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .m_req(mReq), .m_ack(mAck),
        .s_valid(sValid), .s_ready(sReady), .d_done(dDone),
        .grant_oh(grantOh), .grant_id(grantId), .busy(busy), .tmo_err(tmoErr)
    );

    axb_slv_arb #(
        .MSTN(4), .MST_MASK(4'b1011), .TMO_W(8), .TMO_MAX(8'd10)
    ) u_msk (
        .clk(clk), .rst_n(rst_n), .m_req(mReqB), .m_ack(mAckB),
        .s_valid(sValidB), .s_ready(sReady), .d_done(dDone),
        .grant_oh(grantOhB), .grant_id(grantIdB), .busy(busyB), .tmo_err(tmoErrB)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic       done;
        logic       expValid;
        logic [3:0] expAck;
        int         expId;
        logic       expBusy;
    } vec_t;

    vec_t tbl[10];

    task automatic checkVal(input string name, input int act, input int exp);
        testsRun++;
        if (act != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mdlPhase = 0;
        mdlOwner = 0;
        mdlPtr   = 0;
        mdlCnt   = 0;
    endtask

    // Drive inputs just after the rising edge, then wait to the falling edge.
    task automatic applyStimulus(input logic [3:0] req, input logic rdy, input logic done);
        @(posedge clk);
        #1;
        mReq   = req;
        sReady = rdy;
        dDone  = done;
        @(negedge clk);
    endtask

    // Compare the main instance against the model, then advance the model.
    task automatic checkOutput();
        logic       expValid, expBusy, expTmo;
        logic [3:0] expAck, expOh, elig;
        int         expId;
        bit         found;
        expValid = 1'b0; expAck = '0; expOh = '0; expId = 0;
        expBusy = 1'b0; expTmo = 1'b0;
        if (mdlPhase == 1) begin
            expValid = mReq[mdlOwner];
            expAck   = sReady ? 4'(1 << mdlOwner) : 4'b0000;
            expOh    = 4'(1 << mdlOwner);
            expId    = mdlOwner;
            expBusy  = 1'b1;
        end else if (mdlPhase == 2) begin
            expOh   = 4'(1 << mdlOwner);
            expId   = mdlOwner;
            expBusy = 1'b1;
            expTmo  = (mdlCnt == TMO) && !dDone;
        end
        checkVal("model s_valid", int'(sValid), int'(expValid));
        checkVal("model m_ack", int'(mAck), int'(expAck));
        checkVal("model grant_oh", int'(grantOh), int'(expOh));
        checkVal("model grant_id", int'(grantId), expId);
        checkVal("model busy", int'(busy), int'(expBusy));
        checkVal("model tmo_err", int'(tmoErr), int'(expTmo));

        if (mdlPhase == 0) begin
            elig  = mReq & 4'b1111;
            found = 0;
            for (int k = 0; k < N; k++) begin
                if (!found && elig[(mdlPtr + k) % N]) begin
                    mdlOwner = (mdlPtr + k) % N;
                    found    = 1;
                end
            end
            if (found) mdlPhase = 1;
        end else if (mdlPhase == 1) begin
            if (mReq[mdlOwner] && sReady) begin
                mdlPhase = 2;
                mdlCnt   = 0;
            end
        end else begin
            if (dDone || mdlCnt == TMO) begin
                mdlPhase = 0;
                mdlPtr   = (mdlOwner + 1) % N;
            end else if (mdlCnt < TMO) begin
                mdlCnt++;
            end
        end
    endtask

    task automatic runCycle(input logic [3:0] req, input logic rdy, input logic done);
        applyStimulus(req, rdy, done);
        checkOutput();
    endtask

    task automatic doReset();
        mReq = '0; mReqB = '0; sReady = 1'b0; dDone = 1'b0;
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        int pulses, pulseAt;
        modelReset();

        tbl[0] = '{4'b0100, 1'b1, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[1] = '{4'b0100, 1'b1, 1'b0, 1'b1, 4'b0100, 2, 1'b1};
        tbl[2] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b1};
        tbl[3] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b1};
        tbl[4] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2, 1'b1};
        tbl[5] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2, 1'b1};
        tbl[6] = '{4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 0, 1'b0};
        tbl[7] = '{4'b1111, 1'b1, 1'b0, 1'b1, 4'b1000, 3, 1'b1};
        tbl[8] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 3, 1'b1};
        tbl[9] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0, 1'b0};

        // Reset values
        doReset();
        #1;
        checkVal("reset grant_oh", int'(grantOh), 0);
        checkVal("reset grant_id", int'(grantId), 0);
        checkVal("reset busy", int'(busy), 0);
        checkVal("reset s_valid", int'(sValid), 0);
        checkVal("reset m_ack", int'(mAck), 0);
        checkVal("reset tmo_err", int'(tmoErr), 0);

        // Single request, then pointer at 3 picks master 3 first
        for (int i = 0; i < 10; i++) begin
            runCycle(tbl[i].req, tbl[i].rdy, tbl[i].done);
            checkVal("tbl s_valid", int'(sValid), int'(tbl[i].expValid));
            checkVal("tbl m_ack", int'(mAck), int'(tbl[i].expAck));
            checkVal("tbl grant_id", int'(grantId), tbl[i].expId);
            checkVal("tbl busy", int'(busy), int'(tbl[i].expBusy));
            checkVal("tbl grant_oh", int'(grantOh),
                     tbl[i].expBusy ? (1 << tbl[i].expId) : 0);
        end

        // Round-robin under full contention
        doReset();
        for (int t = 0; t < 5; t++) begin
            runCycle(4'b1111, 1'b1, 1'b0);
            runCycle(4'b1111, 1'b1, 1'b0);
            checkVal("rr grant_id", int'(grantId), t % N);
            checkVal("rr m_ack", int'(mAck), 1 << (t % N));
            runCycle(4'b1111, 1'b1, 1'b0);
            runCycle(4'b1111, 1'b1, 1'b1);
        end

        // Masked-off master never acknowledged
        doReset();
        mReqB = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            runCycle(4'b0000, 1'b1, 1'b0);
            checkVal("mask m_ack", int'(mAckB), 0);
            checkVal("mask busy", int'(busyB), 0);
        end
        mReqB = 4'b0110;
        runCycle(4'b0000, 1'b1, 1'b0);
        checkVal("mask grant_id", int'(grantIdB), 1);
        checkVal("mask m_ack grant", int'(mAckB), 4'b0010);
        runCycle(4'b0000, 1'b1, 1'b0);
        mReqB = 4'b0000;
        runCycle(4'b0000, 1'b0, 1'b1);
        runCycle(4'b0000, 1'b0, 1'b0);
        checkVal("mask release", int'(busyB), 0);

        // Slave stall
        doReset();
        runCycle(4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            runCycle(4'b1000, 1'b0, 1'b0);
            checkVal("stall s_valid", int'(sValid), 1);
            checkVal("stall m_ack", int'(mAck), 0);
            checkVal("stall grant_oh", int'(grantOh), 4'b1000);
        end
        runCycle(4'b1000, 1'b1, 1'b0);
        checkVal("stall ack", int'(mAck), 4'b1000);
        runCycle(4'b0000, 1'b0, 1'b0);
        checkVal("stall data s_valid", int'(sValid), 0);
        checkVal("stall data busy", int'(busy), 1);
        runCycle(4'b0000, 1'b0, 1'b1);

        // Watchdog fires on the 11th data cycle
        doReset();
        runCycle(4'b0001, 1'b1, 1'b0);
        runCycle(4'b0001, 1'b1, 1'b0);
        pulses = 0; pulseAt = 0;
        for (int i = 1; i <= 11; i++) begin
            runCycle(4'b0000, 1'b0, 1'b0);
            if (tmoErr) begin
                pulses++;
                pulseAt = i;
            end
        end
        checkVal("tmo pulse count", pulses, 1);
        checkVal("tmo pulse cycle", pulseAt, 11);
        runCycle(4'b1111, 1'b1, 1'b0);
        checkVal("tmo idle after", int'(busy), 0);
        runCycle(4'b1111, 1'b1, 1'b0);
        checkVal("tmo ptr advanced", int'(grantId), 1);
        pulses = 0;
        for (int i = 1; i <= 11; i++) begin
            runCycle(4'b0000, 1'b0, (i == 11));
            if (tmoErr) pulses++;
        end
        checkVal("tmo with done", pulses, 0);
        runCycle(4'b0000, 1'b0, 1'b0);
        checkVal("done at tmo idle", int'(busy), 0);

        // Asynchronous reset mid-data clears pointer left at 3
        doReset();
        runCycle(4'b0100, 1'b1, 1'b0);
        runCycle(4'b0100, 1'b1, 1'b0);
        runCycle(4'b0000, 1'b0, 1'b1);
        runCycle(4'b1000, 1'b1, 1'b0);
        runCycle(4'b1000, 1'b1, 1'b0);
        checkVal("pre-reset grant", int'(grantId), 3);
        runCycle(4'b0000, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkVal("async grant_oh", int'(grantOh), 0);
        checkVal("async busy", int'(busy), 0);
        checkVal("async s_valid", int'(sValid), 0);
        modelReset();
        mReq = '0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        runCycle(4'b1010, 1'b1, 1'b0);
        runCycle(4'b1010, 1'b1, 1'b0);
        checkVal("post-reset grant", int'(grantId), 1);
        runCycle(4'b0000, 1'b0, 1'b1);

        // Randomized traffic against the model
        doReset();
        for (int i = 0; i < 1200; i++) begin
            logic [3:0] r;
            logic       rd, dn;
            r  = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 3) != 0);
            if (i < 600) dn = ($urandom_range(0, 3) == 0);
            else         dn = ($urandom_range(0, 19) == 0);
            runCycle(r, rd, dn);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/axb_slv_arb.md
Name: axb_slv_arb

Overview:
- Per-slave write/read address arbiter for the AXB crossbar (MSTN masters, one slave port).
- One instance sits in front of each s_a_<n> slave port. It picks one requesting master with round-robin priority, forwards its address handshake, and holds the grant until the transaction's last data beat completes.
- A watchdog releases a grant whose data phase hangs.

Parameters:
- MSTN, 4, number of masters competing for this slave.
- MST_MASK, 4'b1111, bit i = 1 means master i may access this slave. Requests from masked-off masters are ignored and never acknowledged.
- TMO_W, 8, watchdog counter width.
- TMO_MAX, 8'd200, data-phase cycles before forced release.
- IDW, $clog2(MSTN), width of grant_id.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m_req  in  MSTN  per-master address valid.
- m_ack  out  MSTN  per-master address ready (one-hot or zero).
- s_valid  out  1  address valid toward slave.
- s_ready  in  1  slave address ready.
- d_done  in  1  last data/response beat handshaken on the granted path.
- grant_oh  out  MSTN  one-hot current owner (steers crossbar mux).
- grant_id  out  IDW  binary encoding of owner.
- busy  out  1  high in ADDR or DATA.
- tmo_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
Interface:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, grant_oh=0, grant_id=0, rr_ptr=0, tmo_cnt=0, s_valid=0, m_ack=0, busy=0, tmo_err=0.

States: IDLE, ADDR, DATA.

IDLE:
- Arbitration runs when eligible = m_req & MST_MASK is nonzero.
- Winner is the first set bit of eligible at or after rr_ptr, wrapping MSTN-1 -> 0.
- On the next edge: grant_oh/grant_id register the winner and state -> ADDR. Latency from request to s_valid is 1 cycle.
- If eligible is 0, stay in IDLE.

ADDR:
- s_valid = m_req[grant_id]; m_ack[grant_id] = s_ready; all other m_ack bits are 0.
- On s_valid & s_ready: -> DATA and clear tmo_cnt.
- If the granted master drops m_req before the handshake (protocol violation), hold the grant and wait. Do not re-arbitrate.

DATA:
- s_valid = 0 and m_ack = 0.
- tmo_cnt increments each cycle and saturates at TMO_MAX.
- On d_done: -> IDLE and rr_ptr = (grant_id+1) mod MSTN.
- If tmo_cnt == TMO_MAX without d_done: pulse tmo_err, -> IDLE, and advance rr_ptr as on completion.
- d_done and timeout in the same cycle count as normal completion; no tmo_err.
- d_done outside DATA is ignored.

Other rules:
- grant_oh and grant_id stay stable from entering ADDR until leaving DATA, and are cleared to 0 on return to IDLE.
- An IDLE cycle always separates two grants, so there is no back-to-back re-grant without arbitration.
- rr_ptr changes only on leaving DATA, which gives starvation-freedom: with all MSTN masters requesting continuously, each is granted within MSTN transactions.
- Reset asserted mid-transaction aborts immediately to the reset values. No completion is signalled.

Decomposition:
- axb_pkg holds:
  - the state enum (IDLE/ADDR/DATA)
  - the default MSTN and SLVN constants (4, 8)
  - function onehot2bin
- One combinational sub-module, axb_rr_pick: inputs eligible and rr_ptr, outputs winner one-hot and winner id. It is reused by the read-channel arbiter.

Test Plan:
1. Single request: m_req=4'b0100 at cycle 0, s_ready=1 -> grant_id=2 and s_valid=1 at cycle 1, m_ack=4'b0100 at cycle 1, DATA at cycle 2. d_done at cycle 5 -> IDLE at cycle 6, rr_ptr=3.
2. Round-robin contention: m_req=4'b1111 held, d_done 2 cycles after each address handshake -> grant sequence 0,1,2,3,0. No other m_ack bit ever high.
3. Mask: MST_MASK=4'b1011 with m_req=4'b0100 -> stays in IDLE with m_ack=0 indefinitely. Then m_req=4'b0110 -> grant_id=1.
4. Slave stall: grant master 3 with s_ready=0 for 7 cycles -> s_valid high and m_ack=0 throughout, grant stable. s_ready=1 on cycle 8 -> m_ack=4'b1000 for one cycle, then DATA.
5. Watchdog: TMO_MAX=10, no d_done in DATA -> tmo_err pulses exactly once on the 11th DATA cycle, then IDLE with rr_ptr advanced. With d_done on that same cycle -> no tmo_err.
6. Reset mid-DATA: assert rst_n=0 asynchronously between edges -> grant_oh, busy and s_valid are 0 immediately. After release, m_req=4'b0010 -> grant_id=1, since rr_ptr was reset to 0.
